// File: rtl/reflet_exti_n_pkg.sv
// reflet_exti_n_pkg: shared register map and field types for the interrupt controller
package reflet_exti_n_pkg;
`include "reflet_exti_n_defs.vh"
  typedef logic [ROUTE_W-1:0] route_t;
endpackage

// File: rtl/reflet_exti_n_chan.sv
// reflet_exti_n_chan: one interrupt source: 2-flop synchronizer, edge detector and pending flop
module reflet_exti_n_chan (
  input  logic clk,
  input  logic reset,
  input  logic int_in,
  input  logic mode,
  input  logic mode_chg,
  input  logic clr,
  output logic pending
);
  logic s1, s, prev, pend_q;
  // prev always tracks s, so a mode switch never sees a stale edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b0;
      s <= 1'b0;
      prev <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      s1 <= int_in;
      s <= s1;
      prev <= s;
      pend_q <= mode_chg ? 1'b0 : mode & ((s & ~prev) | (pend_q & ~clr));
    end
  assign pending = mode ? pend_q : s;
endmodule

// File: rtl/reflet_exti_n_defs.vh
// reflet_exti_n_defs: register offsets relative to base_addr and ROUTE field width
localparam int OFF_ENABLE = 0;
localparam int OFF_MODE = 1;
localparam int OFF_PENDING = 2;
localparam int OFF_ROUTE = 3;
localparam int ROUTE_W = 2;

// File: rtl/reflet_exti_n.sv
// reflet_exti_n: memory-mapped external interrupt controller with per-source edge/level mode and 4-line routing
module reflet_exti_n
  import reflet_exti_n_pkg::*;
#(
  parameter int wordsize = 8,
  parameter int base_addr_size = 7,
  parameter int base_addr = 0,
  parameter int num_src = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [num_src-1:0]        int_in,
  output logic [3:0]                cpu_int
);
  int off;
  logic sel, wr, unused_ok;
  logic [num_src-1:0] enable_r, mode_r, pend, mode_chg, clr;
  route_t route_r [num_src];
  // offset computed in int so addresses past the top of the bus never wrap into the map
  assign off = int'(addr) - base_addr;
  assign sel = enable && off >= 0 && off < OFF_ROUTE + num_src;
  assign wr = sel && write_en;
  assign mode_chg = (wr && off == OFF_MODE) ? data_in[num_src-1:0] ^ mode_r : '0;
  assign clr = (wr && off == OFF_PENDING) ? data_in[num_src-1:0] : '0;
  assign unused_ok = &{1'b0, data_in};
  for (genvar g = 0; g < num_src; g++) begin : g_chan
    reflet_exti_n_chan u_chan (
      .clk(clk),
      .reset(reset),
      .int_in(int_in[g]),
      .mode(mode_r[g]),
      .mode_chg(mode_chg[g]),
      .clr(clr[g]),
      .pending(pend[g])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      enable_r <= '0;
      mode_r <= '0;
      for (int i = 0; i < num_src; i++) route_r[i] <= '0;
    end else if (wr) begin
      if (off == OFF_ENABLE) enable_r <= data_in[num_src-1:0];
      if (off == OFF_MODE) mode_r <= data_in[num_src-1:0];
      for (int i = 0; i < num_src; i++)
        if (off == OFF_ROUTE + i) route_r[i] <= data_in[ROUTE_W-1:0];
    end
  always_comb begin
    data_out = '0;
    if (sel && off == OFF_ENABLE) data_out[num_src-1:0] = enable_r;
    if (sel && off == OFF_MODE) data_out[num_src-1:0] = mode_r;
    if (sel && off == OFF_PENDING) data_out[num_src-1:0] = pend;
    for (int i = 0; i < num_src; i++)
      if (sel && off == OFF_ROUTE + i) data_out[ROUTE_W-1:0] = route_r[i];
  end
  always_comb begin
    cpu_int = '0;
    for (int i = 0; i < num_src; i++)
      if (pend[i] && enable_r[i]) cpu_int[route_r[i]] = 1'b1;
  end
endmodule
